// File: rtl/ahb_burst_sequencer.sv
// AHB burst sequencer: expands one CPU request into NONSEQ/SEQ address phases separated by BUSY gaps.
// Optional feature macro AHB_SEQ_ERR_ABORT_EN: an error response aborts the burst instead of setting a sticky err.
module ahb_burst_sequencer #(
    parameter int MAX_INCR_LEN = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_burst,
    input  logic       req_write,
    input  logic [4:0] req_len,
    input  logic       HREADY,
    input  logic       HRESP,
    output logic [1:0] HTRANS,
    output logic [2:0] HBURST,
    output logic       HWRITE,
    output logic [2:0] HSIZE,
    output logic       addr_en,
    output logic [4:0] beat_cnt,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [4:0] MAX_LEN   = 5'(MAX_INCR_LEN);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP,
        DATA,
        ERR
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [1:0] htrans_q;
    logic [1:0] htrans_d;
    logic [2:0] hburst_q;
    logic [2:0] hburst_d;
    logic       hwrite_q;
    logic       hwrite_d;
    logic       addr_en_q;
    logic       addr_en_d;
    logic [4:0] beat_cnt_q;
    logic [4:0] beat_cnt_d;
    logic [4:0] beat_total;
    logic [4:0] beat_total_d;
    logic [4:0] req_total;
    logic       done_q;
    logic       done_d;
    logic       err_q;
    logic       err_d;
    logic       accept;
    logic       last_beat;
    logic       abort;

    // A done cycle is already IDLE, but a request seen alongside done must not start a burst.
    assign req_ready = (state == IDLE) && !done_q;
    assign accept    = req_valid && req_ready;
    assign last_beat = (beat_cnt_q + 5'd1) >= beat_total;

`ifdef AHB_SEQ_ERR_ABORT_EN
    assign abort = HRESP && !HREADY;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        req_total = 5'd16;
        case (req_burst)
            3'b000: req_total = 5'd1;
            3'b001: begin
                if (req_len == 5'd0) begin
                    req_total = 5'd1;
                end else if (req_len > MAX_LEN) begin
                    req_total = MAX_LEN;
                end else begin
                    req_total = req_len;
                end
            end
            3'b010, 3'b011: req_total = 5'd4;
            3'b100, 3'b101: req_total = 5'd8;
            default:        req_total = 5'd16;
        endcase
    end

    always_comb begin
        state_d      = state;
        htrans_d     = htrans_q;
        hburst_d     = hburst_q;
        hwrite_d     = hwrite_q;
        addr_en_d    = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        beat_total_d = beat_total;
        done_d       = 1'b0;
`ifdef AHB_SEQ_ERR_ABORT_EN
        err_d        = 1'b0;
`else
        err_d        = err_q | HRESP;
`endif

        case (state)
            IDLE: begin
                if (accept) begin
                    state_d      = ADDR;
                    htrans_d     = TR_NONSEQ;
                    hburst_d     = req_burst;
                    hwrite_d     = req_write;
                    beat_cnt_d   = 5'd0;
                    beat_total_d = req_total;
                    err_d        = 1'b0;
                end
            end
            ADDR: begin
                if (abort) begin
                    state_d  = ERR;
                    htrans_d = TR_IDLE;
                end else if (HREADY) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                    addr_en_d  = 1'b1;
                    if (last_beat) begin
                        state_d  = DATA;
                        htrans_d = TR_IDLE;
                    end else begin
                        state_d  = GAP;
                        htrans_d = TR_BUSY;
                    end
                end
            end
            GAP: begin
                // The BUSY gap guarantees addr_en drops between beats for the edge-triggered address stage.
                if (abort) begin
                    state_d  = ERR;
                    htrans_d = TR_IDLE;
                end else if (HREADY) begin
                    state_d  = ADDR;
                    htrans_d = TR_SEQ;
                end
            end
            DATA: begin
                if (abort) begin
                    state_d  = ERR;
                    htrans_d = TR_IDLE;
                end else if (HREADY) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ERR: begin
                if (HREADY) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                htrans_d = TR_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            htrans_q   <= TR_IDLE;
            hburst_q   <= 3'b000;
            hwrite_q   <= 1'b0;
            addr_en_q  <= 1'b0;
            beat_cnt_q <= 5'd0;
            beat_total <= 5'd1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_d;
            htrans_q   <= htrans_d;
            hburst_q   <= hburst_d;
            hwrite_q   <= hwrite_d;
            addr_en_q  <= addr_en_d;
            beat_cnt_q <= beat_cnt_d;
            beat_total <= beat_total_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign HTRANS   = htrans_q;
    assign HBURST   = hburst_q;
    assign HWRITE   = hwrite_q;
    assign HSIZE    = 3'b010;
    assign addr_en  = addr_en_q;
    assign beat_cnt = beat_cnt_q;
    assign done     = done_q;
    assign err      = err_q;

    a_cnt_bounded: assert property (@(posedge HCLK) disable iff (!HRESETn)
        beat_cnt_q <= beat_total);
    a_addr_en_gap: assert property (@(posedge HCLK) disable iff (!HRESETn)
        addr_en_q |=> !addr_en_q);
    a_done_pulse: assert property (@(posedge HCLK) disable iff (!HRESETn)
        done_q |=> !done_q);

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Randomized bench for ahb_burst_sequencer: each burst's expected cycle trace is built from the burst
// rules and a chosen wait-state pattern, then replayed against the DUT cycle by cycle.
`timescale 1ns/1ps
module tb_ahb_burst_sequencer;

    localparam int MAX_LEN = 16;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic       HCLK;
    logic       HRESETn;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_burst;
    logic       req_write;
    logic [4:0] req_len;
    logic       HREADY;
    logic       HRESP;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HWRITE;
    logic [2:0] HSIZE;
    logic       addr_en;
    logic [4:0] beat_cnt;
    logic       done;
    logic       err;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_burst_sequencer #(.MAX_INCR_LEN(MAX_LEN)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_burst(req_burst),
        .req_write(req_write),
        .req_len  (req_len),
        .HREADY   (HREADY),
        .HRESP    (HRESP),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .addr_en  (addr_en),
        .beat_cnt (beat_cnt),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        bit         hready;
        bit         hresp;
        bit         junk_valid;
        logic [1:0] htrans;
        bit         addr_en;
        int         beat_cnt;
        bit         done;
        bit         err;
    } cycle_t;

    cycle_t trace[$];
    int     addr_wait[32];
    int     gap_wait[32];
    int     data_wait;
    int     err_wait;
    int     compared;
    int     mismatched;
    bit     err_level;
    bit     aborted;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int burst_beats(input logic [2:0] burst, input logic [4:0] len);
        int n;
        n = int'(len);
        case (burst)
            3'b000:         return 1;
            3'b001:         return (n == 0) ? 1 : ((n > MAX_LEN) ? MAX_LEN : n);
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    function automatic cycle_t make_cycle(input bit hready, input logic [1:0] htrans, input bit aen,
                                          input int cnt, input bit dn);
        cycle_t c;
        c.hready     = hready;
        c.hresp      = 1'b0;
        c.junk_valid = 1'($urandom_range(0, 1));
        c.htrans     = htrans;
        c.addr_en    = aen;
        c.beat_cnt   = cnt;
        c.done       = dn;
        c.err        = 1'b0;
        return c;
    endfunction

    task automatic set_waits(input int max_wait);
        for (int i = 0; i < 32; i++) begin
            addr_wait[i] = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, max_wait));
            gap_wait[i]  = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, max_wait));
        end
        data_wait = int'($urandom_range(0, max_wait));
        err_wait  = int'($urandom_range(0, max_wait));
    endtask

    // Each beat: address cycles (waits then accept), then BUSY gap or final IDLE data wait, then done.
    task automatic build_trace(input int total);
        cycle_t c;
        trace.delete();
        for (int b = 0; b < total; b++) begin
            for (int k = 0; k <= addr_wait[b]; k++) begin
                trace.push_back(make_cycle(k == addr_wait[b], (b == 0) ? T_NONSEQ : T_SEQ, 1'b0, b, 1'b0));
            end
            if (b < total - 1) begin
                for (int k = 0; k <= gap_wait[b]; k++) begin
                    trace.push_back(make_cycle(k == gap_wait[b], T_BUSY, k == 0, b + 1, 1'b0));
                end
            end else begin
                for (int k = 0; k <= data_wait; k++) begin
                    trace.push_back(make_cycle(k == data_wait, T_IDLE, k == 0, total, 1'b0));
                end
            end
        end
        c = make_cycle(1'($urandom_range(0, 1)), T_IDLE, 1'b0, total, 1'b1);
        c.junk_valid = 1'b1;
        trace.push_back(c);
    endtask

    function automatic int pick_error_index(input int want_cnt);
        int cands[$];
        for (int i = 0; i < trace.size(); i++) begin
            if (!trace[i].hready && !trace[i].done && (want_cnt < 0 || trace[i].beat_cnt == want_cnt)) begin
                cands.push_back(i);
            end
        end
        if (cands.size() == 0) return -1;
        if (want_cnt >= 0) return cands[0];
        return cands[$urandom_range(0, cands.size() - 1)];
    endfunction

    task automatic inject_error(input int idx);
        cycle_t c;
        c = trace[idx];
        c.hresp = 1'b1;
        trace[idx] = c;
`ifdef AHB_SEQ_ERR_ABORT_EN
        begin
            int held;
            held = trace[idx].beat_cnt;
            while (trace.size() > idx + 1) void'(trace.pop_back());
            for (int k = 0; k <= err_wait; k++) begin
                trace.push_back(make_cycle(k == err_wait, T_IDLE, 1'b0, held, 1'b0));
            end
            c = make_cycle(1'($urandom_range(0, 1)), T_IDLE, 1'b0, held, 1'b1);
            c.err        = 1'b1;
            c.junk_valid = 1'b1;
            trace.push_back(c);
            aborted = 1'b1;
        end
`endif
    endtask

    task automatic check_reset_outputs(input string where);
        checkOutput({where, "_htrans"}, HTRANS, T_IDLE);
        checkOutput({where, "_hburst"}, HBURST, 3'b000);
        checkOutput({where, "_hwrite"}, HWRITE, 1'b0);
        checkOutput({where, "_hsize"}, HSIZE, 3'b010);
        checkOutput({where, "_addr_en"}, addr_en, 1'b0);
        checkOutput({where, "_beat_cnt"}, beat_cnt, 5'd0);
        checkOutput({where, "_done"}, done, 1'b0);
        checkOutput({where, "_err"}, err, 1'b0);
        checkOutput({where, "_req_ready"}, req_ready, 1'b1);
    endtask

    // Called at posedge+1 of an idle cycle; err_sel -1 none, -2 random, else beat_cnt to fault at.
    task automatic applyStimulus(input logic [2:0] burst, input bit write, input logic [4:0] len,
                                 input int err_sel, input int rst_cnt);
        int total;
        int idx;
        int rst_idx;
        int pulses;
        total   = burst_beats(burst, len);
        aborted = 1'b0;
        build_trace(total);
        if (err_sel != -1) begin
            idx = pick_error_index((err_sel == -2) ? -1 : err_sel);
            if (idx >= 0) inject_error(idx);
        end
        rst_idx = -1;
        if (rst_cnt >= 0) begin
            for (int i = 0; i < trace.size(); i++) begin
                if (rst_idx < 0 && trace[i].beat_cnt == rst_cnt &&
                    (trace[i].htrans == T_SEQ || trace[i].htrans == T_NONSEQ)) rst_idx = i;
            end
        end

        checkOutput("idle_req_ready", req_ready, 1'b1);
        checkOutput("idle_htrans", HTRANS, T_IDLE);
        checkOutput("idle_done", done, 1'b0);
        checkOutput("idle_addr_en", addr_en, 1'b0);
        checkOutput("idle_err", err, err_level);
        req_valid = 1'b1;
        req_burst = burst;
        req_write = write;
        req_len   = len;
        HREADY    = 1'($urandom_range(0, 1));
        HRESP     = 1'b0;
        @(posedge HCLK);
        #1;
        err_level = 1'b0;
        pulses    = 0;

        for (int i = 0; i < trace.size(); i++) begin
            checkOutput("htrans", HTRANS, trace[i].htrans);
            checkOutput("addr_en", addr_en, trace[i].addr_en);
            checkOutput("beat_cnt", beat_cnt, trace[i].beat_cnt);
            checkOutput("done", done, trace[i].done);
            checkOutput("busy_req_ready", req_ready, 1'b0);
            checkOutput("hburst", HBURST, burst);
            checkOutput("hwrite", HWRITE, write);
            checkOutput("hsize", HSIZE, 3'b010);
`ifdef AHB_SEQ_ERR_ABORT_EN
            checkOutput("err", err, trace[i].err);
`else
            checkOutput("err", err, err_level);
`endif
            pulses += int'(addr_en);
            HREADY    = trace[i].hready;
            HRESP     = trace[i].hresp;
            req_valid = trace[i].junk_valid;
            req_burst = 3'($urandom);
            req_write = 1'($urandom);
            req_len   = 5'($urandom);
`ifndef AHB_SEQ_ERR_ABORT_EN
            if (trace[i].hresp) err_level = 1'b1;
`endif
            if (i == rst_idx) begin
                req_valid = 1'b0;
                #2 HRESETn = 1'b0;
                #1;
                check_reset_outputs("async_reset");
                @(negedge HCLK);
                HRESETn   = 1'b1;
                HREADY    = 1'b1;
                HRESP     = 1'b0;
                err_level = 1'b0;
                repeat (3) begin
                    @(posedge HCLK);
                    #1;
                    checkOutput("post_reset_done", done, 1'b0);
                    checkOutput("post_reset_ready", req_ready, 1'b1);
                    checkOutput("post_reset_htrans", HTRANS, T_IDLE);
                end
                return;
            end
            @(posedge HCLK);
            #1;
        end

        req_valid = 1'b0;
        HREADY    = 1'($urandom_range(0, 1));
        HRESP     = 1'b0;
        if (!aborted) checkOutput("addr_en_pulses", pulses, total);
        checkOutput("after_done_htrans", HTRANS, T_IDLE);
        checkOutput("after_done_done", done, 1'b0);
        checkOutput("after_done_ready", req_ready, 1'b1);
        checkOutput("after_done_hburst", HBURST, burst);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        err_level  = 1'b0;
        aborted    = 1'b0;
        HRESETn    = 1'b0;
        req_valid  = 1'b0;
        req_burst  = 3'b000;
        req_write  = 1'b0;
        req_len    = 5'd0;
        HREADY     = 1'b1;
        HRESP      = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check_reset_outputs("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        set_waits(0);
        applyStimulus(3'b000, 1'b1, 5'd0, -1, -1);
        set_waits(0);
        applyStimulus(3'b011, 1'b0, 5'd0, -1, -1);
        set_waits(0);
        addr_wait[2] = 3;
        applyStimulus(3'b100, 1'b1, 5'd0, -1, -1);
        set_waits(0);
        applyStimulus(3'b001, 1'b0, 5'd0, -1, -1);
        set_waits(0);
        applyStimulus(3'b001, 1'b1, 5'd20, -1, -1);
        set_waits(0);
        gap_wait[1] = 2;
        err_wait    = 1;
        applyStimulus(3'b111, 1'b0, 5'd0, 2, -1);
        set_waits(0);
        applyStimulus(3'b101, 1'b1, 5'd0, -1, 4);

        for (int n = 0; n < 40; n++) begin
            set_waits(2);
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) == 0) ? -2 : -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
